// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
//
// Shared types and constants for the 8-bit accumulator CPU controller.
//   state_t     : controller FSM states (also exported on the debug port)
//   ALU_*       : ALU operation codes driven on aluOpControl
//   ADDR_SEL_*  : memory address source (PcOrTR)
//   B_SEL_*     : B operand source (regOrMem)
//   ACC_SEL_*   : accumulator register select (accAddressSel)
//   op_class_t  : instruction class decoded from the opcode IR[7:4]
//   ctrl_out_t  : bundle of every strobe/select the controller drives
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_OPND_M = 4'd3,
    S_OPND_S = 4'd4,
    S_RD_B   = 4'd5,
    S_RD_A   = 4'd6,
    S_EXEC   = 4'd7,
    S_WB     = 4'd8,
    S_MEM_WR = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  // ALU operations. 2'b01 (ADC) exists in the datapath but this
  // instruction set never issues it.
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  // Memory address select
  localparam logic ADDR_SEL_TR = 1'b0;
  localparam logic ADDR_SEL_PC = 1'b1;

  // B operand source
  localparam logic B_SEL_MEM = 1'b0;
  localparam logic B_SEL_ACC = 1'b1;

  // Accumulator register select
  localparam logic [1:0] ACC_SEL_DI = 2'd0;  // DI[4:3], memory-reference register
  localparam logic [1:0] ACC_SEL_RS = 2'd1;  // IR[1:0]
  localparam logic [1:0] ACC_SEL_RD = 2'd2;  // IR[3:2]

  typedef enum logic [3:0] {
    OPC_LOAD  = 4'd0,
    OPC_STORE = 4'd1,
    OPC_ADD_M = 4'd2,
    OPC_AND_M = 4'd3,
    OPC_JMP   = 4'd4,
    OPC_JZ    = 4'd5,
    OPC_ADD_R = 4'd6,
    OPC_AND_R = 4'd7,
    OPC_MOV   = 4'd8,
    OPC_NOT   = 4'd9
  } op_class_t;

  // Opcode layout (IR[7:4]):
  //   0 o o x : memory reference, oo selects LOAD/STORE/ADD/AND
  //   1 0 j x : j=0 JMP, j=1 JZ
  //   1 1 f f : ff selects ADD/AND/MOV/NOT on registers
  // Every one of the 16 codes maps to a class.
  function automatic op_class_t op_class(input logic [3:0] opc);
    op_class_t c;
    if (!opc[3]) begin
      case (opc[2:1])
        2'b00:   c = OPC_LOAD;
        2'b01:   c = OPC_STORE;
        2'b10:   c = OPC_ADD_M;
        default: c = OPC_AND_M;
      endcase
    end else if (!opc[2]) begin
      c = opc[1] ? OPC_JZ : OPC_JMP;
    end else begin
      case (opc[1:0])
        2'b00:   c = OPC_ADD_R;
        2'b01:   c = OPC_AND_R;
        2'b10:   c = OPC_MOV;
        default: c = OPC_NOT;
      endcase
    end
    return c;
  endfunction

  typedef struct packed {
    logic       pc_inc;
    logic       pc_load_en;
    logic       di_load_en;
    logic       ir_write_en;
    logic       tr_write_en;
    logic       a_reg_write_en;
    logic       b_reg_write_en;
    logic       alu_res_write_en;
    logic       ld_czn;
    logic       acc_write_en;
    logic       mem_write_en;
    logic       pc_or_tr;
    logic       reg_or_mem;
    logic       reg_b_or_0;
    logic       reg_a_or_0;
    logic [1:0] acc_address_sel;
    logic [1:0] alu_op;
  } ctrl_out_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// -----------------------------------------------------------------------------
// ctrl_output_decode
//
// Purely combinational map from (state, opcode, Z flag) to every datapath
// strobe and select. Outputs are forced to zero while reset is asserted so no
// write strobe can leak out during reset, even though FETCH is the reset state.
//
// Ports:
//   i_rst_n     in  1           active-low reset (gates all outputs)
//   i_state     in  state_t     current controller state
//   i_opcode    in  4           IR[7:4]
//   i_zero_flag in  1           Z flag, only consulted in JUMP for JZ
//   o_ctrl      out ctrl_out_t  all controller outputs
// -----------------------------------------------------------------------------
module ctrl_output_decode
  import cpu_ctrl_pkg::*;
(
  input  logic       i_rst_n,
  input  state_t     i_state,
  input  logic [3:0] i_opcode,
  input  logic       i_zero_flag,
  output ctrl_out_t  o_ctrl
);

  op_class_t w_class;

  assign w_class = op_class(i_opcode);

  always_comb begin
    o_ctrl = '0;
    if (i_rst_n) begin
      case (i_state)
        S_FETCH: begin
          o_ctrl.pc_or_tr    = ADDR_SEL_PC;
          o_ctrl.ir_write_en = 1'b1;
          o_ctrl.pc_inc      = 1'b1;
        end
        S_DECODE: begin
          o_ctrl.di_load_en = 1'b1;
        end
        S_ADDR: begin
          // Second instruction byte (low address bits) goes into TR.
          o_ctrl.pc_or_tr    = ADDR_SEL_PC;
          o_ctrl.tr_write_en = 1'b1;
          o_ctrl.pc_inc      = 1'b1;
        end
        S_OPND_M: begin
          // B <- mem[TR], A <- ACC[DI[4:3]] in the same cycle.
          o_ctrl.pc_or_tr        = ADDR_SEL_TR;
          o_ctrl.reg_or_mem      = B_SEL_MEM;
          o_ctrl.b_reg_write_en  = 1'b1;
          o_ctrl.acc_address_sel = ACC_SEL_DI;
          o_ctrl.a_reg_write_en  = 1'b1;
        end
        S_OPND_S: begin
          // STORE: B <- ACC[DI[4:3]], passed through the ALU to memory.
          o_ctrl.acc_address_sel = ACC_SEL_DI;
          o_ctrl.reg_or_mem      = B_SEL_ACC;
          o_ctrl.b_reg_write_en  = 1'b1;
        end
        S_RD_B: begin
          // NOT has only Rd, so its single operand is read from the Rd field.
          o_ctrl.reg_or_mem      = B_SEL_ACC;
          o_ctrl.b_reg_write_en  = 1'b1;
          o_ctrl.acc_address_sel = (w_class == OPC_NOT) ? ACC_SEL_RD : ACC_SEL_RS;
        end
        S_RD_A: begin
          o_ctrl.acc_address_sel = ACC_SEL_RD;
          o_ctrl.a_reg_write_en  = 1'b1;
        end
        S_EXEC: begin
          o_ctrl.alu_res_write_en = 1'b1;
          case (w_class)
            // Pure moves: result = 0 + B, flags untouched.
            OPC_LOAD, OPC_STORE, OPC_MOV: begin
              o_ctrl.alu_op     = ALU_ADD;
              o_ctrl.reg_a_or_0 = 1'b1;
            end
            OPC_ADD_M, OPC_ADD_R: begin
              o_ctrl.alu_op = ALU_ADD;
              o_ctrl.ld_czn = 1'b1;
            end
            OPC_AND_M, OPC_AND_R: begin
              o_ctrl.alu_op = ALU_AND;
              o_ctrl.ld_czn = 1'b1;
            end
            OPC_NOT: begin
              o_ctrl.alu_op = ALU_NOTB;
              o_ctrl.ld_czn = 1'b1;
            end
            default: begin
              // Jumps never reach EXEC.
            end
          endcase
        end
        S_WB: begin
          o_ctrl.acc_write_en    = 1'b1;
          // Memory-reference ops (IR[7]=0) address ACC via DI, register ops via Rd.
          o_ctrl.acc_address_sel = i_opcode[3] ? ACC_SEL_RD : ACC_SEL_DI;
        end
        S_MEM_WR: begin
          o_ctrl.pc_or_tr     = ADDR_SEL_TR;
          o_ctrl.mem_write_en = 1'b1;
        end
        S_JUMP: begin
          // Flags written by the previous instruction are already visible here.
          o_ctrl.pc_load_en = (w_class == OPC_JMP) ? 1'b1 : i_zero_flag;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Multi-cycle Moore controller for the 8-bit accumulator CPU. Holds the state
// register and next-state logic; ctrl_output_decode turns the state plus the
// opcode into datapath strobes. Instructions take 4 (jumps), 5 (MOV/NOT) or
// 6 (everything else) cycles.
//
// Ports:
//   clk                 in  1  system clock, rising edge
//   rst                 in  1  asynchronous active-low reset
//   IrToCU              in  4  opcode IR[7:4]
//   CznToCU             in  3  flags [0]=C [1]=Z [2]=N (only Z is used)
//   DiToCU              in  5  DI contents, reserved
//   pcInc .. memoryWriteEn  out 1  register / architectural write strobes
//   PcOrTR              out 1  memory address: 0=TR 1=PC
//   regOrMem            out 1  B source: 0=memory 1=accumulator
//   RegBOr0, RegAOr0    out 1  ALU operand forced to zero when 1
//   accAddressSel       out 2  0=DI[4:3] 1=Rs 2=Rd
//   aluOpControl        out 2  00=ADD 01=ADC 10=AND 11=NOT B
//   o_dbg_state         out 4  current FSM state for observation
//
// Handshake: none; the datapath obeys every strobe in the cycle it is high.
// -----------------------------------------------------------------------------
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] IrToCU,
  input  logic [2:0] CznToCU,
  input  logic [4:0] DiToCU,
  output logic       pcInc,
  output logic       pcLoadEn,
  output logic       diLoadEn,
  output logic       irWriteEn,
  output logic       trWriteEn,
  output logic       aRegWriteEn,
  output logic       bRegWriteEn,
  output logic       aluResWriteEn,
  output logic       ldCZN,
  output logic       accumulatorWriteEn,
  output logic       memoryWriteEn,
  output logic       PcOrTR,
  output logic       regOrMem,
  output logic       RegBOr0,
  output logic       RegAOr0,
  output logic [1:0] accAddressSel,
  output logic [1:0] aluOpControl,
  output state_t     o_dbg_state
);

  state_t    r_state;
  state_t    w_next_state;
  op_class_t w_class;
  ctrl_out_t w_ctrl;
  logic      w_unused;

  // IR is stable from the end of FETCH to the next FETCH, so the opcode can
  // be decoded live in every state without a private copy.
  assign w_class = op_class(IrToCU);

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        // Memory-reference ops and jumps carry a second byte.
        if (!IrToCU[3] || (IrToCU[3:2] == 2'b10)) w_next_state = S_ADDR;
        else                                      w_next_state = S_RD_B;
      end
      S_ADDR: begin
        if ((w_class == OPC_JMP) || (w_class == OPC_JZ)) w_next_state = S_JUMP;
        else if (w_class == OPC_STORE)                   w_next_state = S_OPND_S;
        else                                             w_next_state = S_OPND_M;
      end
      S_OPND_M: w_next_state = S_EXEC;
      S_OPND_S: w_next_state = S_EXEC;
      S_RD_B: begin
        // Two-operand register ops also need Rd in A; MOV/NOT go straight on.
        if ((w_class == OPC_ADD_R) || (w_class == OPC_AND_R)) w_next_state = S_RD_A;
        else                                                  w_next_state = S_EXEC;
      end
      S_RD_A:   w_next_state = S_EXEC;
      S_EXEC:   w_next_state = (w_class == OPC_STORE) ? S_MEM_WR : S_WB;
      S_WB:     w_next_state = S_FETCH;
      S_MEM_WR: w_next_state = S_FETCH;
      S_JUMP:   w_next_state = S_FETCH;
      default:  w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next_state;
  end

  ctrl_output_decode u_decode (
    .i_rst_n     (rst),
    .i_state     (r_state),
    .i_opcode    (IrToCU),
    .i_zero_flag (CznToCU[1]),
    .o_ctrl      (w_ctrl)
  );

  assign pcInc              = w_ctrl.pc_inc;
  assign pcLoadEn           = w_ctrl.pc_load_en;
  assign diLoadEn           = w_ctrl.di_load_en;
  assign irWriteEn          = w_ctrl.ir_write_en;
  assign trWriteEn          = w_ctrl.tr_write_en;
  assign aRegWriteEn        = w_ctrl.a_reg_write_en;
  assign bRegWriteEn        = w_ctrl.b_reg_write_en;
  assign aluResWriteEn      = w_ctrl.alu_res_write_en;
  assign ldCZN              = w_ctrl.ld_czn;
  assign accumulatorWriteEn = w_ctrl.acc_write_en;
  assign memoryWriteEn      = w_ctrl.mem_write_en;
  assign PcOrTR             = w_ctrl.pc_or_tr;
  assign regOrMem           = w_ctrl.reg_or_mem;
  assign RegBOr0            = w_ctrl.reg_b_or_0;
  assign RegAOr0            = w_ctrl.reg_a_or_0;
  assign accAddressSel      = w_ctrl.acc_address_sel;
  assign aluOpControl       = w_ctrl.alu_op;
  assign o_dbg_state        = r_state;

  // DI is reserved and C/N are datapath-only; they do not steer control.
  assign w_unused = ^{DiToCU, CznToCU[2], CznToCU[0]};

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle controller for the 8-bit accumulator CPU. It sits opposite the datapath: it consumes the opcode and flag status the datapath exports, and drives every load, write, mux-select and ALU-op strobe the datapath accepts. It sequences fetch, decode, operand read, execute and write-back through a Moore state machine. Each instruction completes in 4 to 6 cycles.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- IrToCU  in  4  IR[7:4], the opcode field
- CznToCU  in  3  flags; [0]=C, [1]=Z, [2]=N
- DiToCU  in  5  DI contents; reserved, ignored
- pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn  out  1 each  datapath register strobes
- aRegWriteEn, bRegWriteEn, aluResWriteEn, ldCZN  out  1 each  operand, result and flag strobes
- accumulatorWriteEn, memoryWriteEn  out  1 each  architectural write strobes
- PcOrTR  out  1  memory address select: 0=TR, 1=PC
- regOrMem  out  1  B source: 0=memory, 1=accumulator
- RegBOr0, RegAOr0  out  1 each  ALU operand select: 0=register, 1=zero
- accAddressSel  out  2  accumulator register select: 0=DI[4:3], 1=IR[1:0] (Rs), 2=IR[3:2] (Rd)
- aluOpControl  out  2  ALU operation: 00=ADD, 01=ADC, 10=AND, 11=NOT B

## Operation
- **Instruction set.** The opcode is IR[7:4].
  - 0oo x: memory-reference, two bytes, address = {byte0[4:0], byte1}, register ACC[DI[4:3]]; oo: 00=LOAD, 01=STORE, 10=ADD, 11=AND.
  - 100x: JMP, two bytes.
  - 101x: JZ, two bytes.
  - 1100: ADD Rd,Rs.
  - 1101: AND Rd,Rs.
  - 1110: MOV Rd,Rs.
  - 1111: NOT Rd.
  - All 16 codes are legal.
- **States.** FETCH, DECODE, ADDR, OPND_M, OPND_S, RD_B, RD_A, EXEC, WB, MEM_WR, JUMP.
- **FETCH:** PcOrTR=1, irWriteEn, pcInc. Next DECODE.
- **DECODE:** diLoadEn. Next ADDR if IR[7]=0 or IR[7:6]=10; otherwise RD_B.
- **ADDR:** PcOrTR=1, trWriteEn, pcInc. Next JUMP for jumps, OPND_S for STORE, else OPND_M.
- **OPND_M:** PcOrTR=0, regOrMem=0, bRegWriteEn, accAddressSel=0, aRegWriteEn. Next EXEC.
- **OPND_S:** accAddressSel=0, regOrMem=1, bRegWriteEn. Next EXEC.
- **RD_B:** regOrMem=1, bRegWriteEn; accAddressSel=2 for NOT, else 1. Next RD_A for ADD/AND; EXEC for MOV/NOT.
- **RD_A:** accAddressSel=2, aRegWriteEn. Next EXEC.
- **EXEC:** aluResWriteEn, with operation by instruction:
  - LOAD, STORE, MOV: aluOp=ADD, RegAOr0=1.
  - ADD: aluOp=ADD.
  - AND: aluOp=AND.
  - NOT: aluOp=NOT.
  - ldCZN is asserted only for ADD, AND and NOT.
  - Next MEM_WR for STORE, else WB.
- **WB:** accumulatorWriteEn; accAddressSel=0 for memory-reference, 2 for register ops. Next FETCH.
- **MEM_WR:** PcOrTR=0, memoryWriteEn. Next FETCH.
- **JUMP:** pcLoadEn=1 for JMP; for JZ, pcLoadEn=CznToCU[1]. Next FETCH.
- **Output defaults.** Any output not listed for a state is 0. PcOrTR, regOrMem, RegBOr0 and RegAOr0 are therefore 0 outside their listed states.
- **Decode source.** IR is stable from the end of FETCH until the next FETCH. The opcode used in every decision is sampled from IrToCU combinationally in the current state.

## Timing
- **Reset.**
  - rst low forces state=FETCH and every output to 0 immediately, including mid-instruction.
  - No write strobe may be seen while rst is low.
  - The first rising edge after release executes FETCH.
- **Output style.** All outputs are Moore outputs of state plus the IrToCU decode. The only flag-dependent output is pcLoadEn in JUMP.
- **Memory.** Memory reads are combinational, so IR, TR and B capture memory data in the same cycle the address is presented.
- **Latency in cycles.**
  - LOAD, STORE, ADD-mem, AND-mem: 6.
  - JMP, JZ: 4.
  - ADD Rd,Rs and AND Rd,Rs: 6.
  - MOV, NOT: 5.
- **Strobe counts.**
  - Every architectural write strobe is exactly one cycle wide.
  - pcInc pulses exactly once for one-byte instructions and twice for two-byte instructions.
- **JZ flags.** JZ reads the flags as they stand in the JUMP cycle. Flags written by the preceding instruction's EXEC are already visible.

## Structure
- **Package cpu_ctrl_pkg** holds:
  - the state enum;
  - the ALU op constants;
  - the PcOrTR, regOrMem and accAddressSel select constants;
  - the opcode class constants.
- **Sub-module ctrl_output_decode** is the natural split: a combinational map from (state, IrToCU, CznToCU) to all outputs. The top level keeps the state register and next-state logic.

## Test plan
- **Reset mid-instruction.** Assert rst=0 during EXEC of an ADD -> all outputs 0 at once. Release -> the next cycle shows irWriteEn=1, pcInc=1, PcOrTR=1.
- **LOAD.** IrToCU=4'b0001 -> six states FETCH,DECODE,ADDR,OPND_M,EXEC,WB. EXEC shows RegAOr0=1, aluOp=00, ldCZN=0. WB shows accumulatorWriteEn=1 with accAddressSel=0.
- **STORE.** IrToCU=4'b0010 -> MEM_WR shows memoryWriteEn=1 and PcOrTR=0 for exactly one cycle. accumulatorWriteEn is never asserted.
- **JZ taken and not taken.** IrToCU=4'b1010 with CznToCU=3'b010 -> pcLoadEn=1 in cycle 4. With CznToCU=3'b000 -> pcLoadEn stays 0 and FETCH follows.
- **ADD Rd,Rs.** IrToCU=4'b1100 -> RD_B (accAddressSel=1, bRegWriteEn), then RD_A (accAddressSel=2, aRegWriteEn), then EXEC (aluOp=00, ldCZN=1), then WB (accAddressSel=2).
- **MOV and NOT.** IrToCU=4'b1110 -> 5 cycles, ldCZN never 1. IrToCU=4'b1111 -> RD_B uses accAddressSel=2, EXEC aluOp=11, ldCZN=1.
